hamming_enc_seq: RTL and testbench
==================================

# hamming_enc_seq

Sequencer for the program-1 Hamming (16,11) encode job. On release of `reset` it walks `NUM_MSG` 11-bit messages from data memory, presents each to an external combinational parity encoder, writes the 16-bit codewords back to data memory, then raises `done`. It sits between the data memory port and the parity unit inside `top_level`. It is pure control and registers only; parity is computed outside it.

## Interface
- `NUM_MSG`, default 15: number of messages per run.
- `SRC_BASE`, default 0: byte address of message 0 low byte.
- `DST_BASE`, default 30: byte address of codeword 0 low byte.
- `AW`, default 8: memory address width; `DST_BASE+2*NUM_MSG-1` and `SRC_BASE+2*NUM_MSG-1` must be < 2^AW (elaboration-time check).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high; also acts as the start request.
- `mem_addr` out AW: byte address for read or write.
- `mem_rd_data` in 8: asynchronous read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en` out 1: write strobe, write takes effect on the rising edge.
- `mem_wr_data` out 8: write data.
- `enc_data` out 11: message to encoder, `{hi[2:0], lo[7:0]}`.
- `enc_code` in 16: encoder result for `enc_data`, same cycle (combinational).
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from run completion until next reset.

## Operation
- Registers: `state`, message index `idx` (width clog2(NUM_MSG+1)), `lo_q[7:0]`, `hi_q[2:0]`, `code_q[15:0]`.
- Reset edge: `state`←RD_LO, `idx`←0, `lo_q/hi_q/code_q`←0. While `reset` is high, `mem_wr_en`=0, `done`=0 and `busy`=0, gated combinationally.
- RD_LO: `mem_addr`=SRC_BASE+2·idx; `lo_q`←`mem_rd_data`; next RD_HI.
- RD_HI: `mem_addr`=SRC_BASE+2·idx+1; `hi_q`←`mem_rd_data[2:0]` (bits [7:3] ignored); next ENC.
- ENC: no memory access (`mem_wr_en`=0, `mem_addr`=SRC_BASE+2·idx+1); `enc_data` stable; `code_q`←`enc_code`; next WR_LO.
- WR_LO: `mem_addr`=DST_BASE+2·idx, `mem_wr_en`=1, `mem_wr_data`=`code_q[7:0]`; next WR_HI.
- WR_HI: `mem_addr`=DST_BASE+2·idx+1, `mem_wr_en`=1, `mem_wr_data`=`code_q[15:8]`. If `idx`==NUM_MSG-1, next is DONE; otherwise `idx`++ and next is RD_LO.
- DONE: `done`=1, `busy`=0, `mem_wr_en`=0, `mem_addr`=0. Holds until the next reset.
- `busy`=1 in RD_LO..WR_HI when `reset` is low.
- `mem_wr_en` is 0 in every state except WR_LO/WR_HI. `mem_wr_data`=0 when not writing.
- `enc_data` always equals `{hi_q, lo_q}`.
- Reset mid-run: restart from message 0 on the next edge. Codewords already written stay in memory and are overwritten by the new run.
- Source and destination regions may not overlap (checked at elaboration). No wrap-around of `mem_addr` is permitted.

## Timing
- Cycle 0 is the first cycle with `reset` low. Message i occupies cycles 5i..5i+4 (RD_LO, RD_HI, ENC, WR_LO, WR_HI).
- Codeword i low byte is written at the end of cycle 5i+3; high byte at the end of cycle 5i+4.
- `done` rises in cycle 5·NUM_MSG (75 for defaults) and is registered, so glitch-free.
- Exactly 2·NUM_MSG write strobes per run; zero writes below DST_BASE.
- Reset held for multiple cycles: the state remains RD_LO/idx 0; the run begins on the first low cycle.

## Test plan
- Defaults, 15 random messages at bytes 0..29, behavioral Hamming model as encoder: `done` at cycle 75, bytes 30..59 match model, bytes 0..29 unchanged.
- All messages 0x000: every codeword byte is 0x00; all messages 0x7FF: every codeword is 0xFFFF (bytes 30..59 = 0xFF).
- High source bytes 0xF8 with low bytes 0x00: `enc_data`=0x000 in each ENC, showing bits [7:3] are ignored.
- Write monitor: exactly 30 strobes, addresses 30,31,…,59 in order, each at cycles 5i+3/5i+4, no strobe while `reset` is high.
- Reset pulsed at cycle 32 (mid message 6): `busy` drops, restart from msg 0, `done` exactly 75 cycles after release, final memory is correct.
- After `done`, run 20 idle cycles: `done` stays 1 with no writes. Second reset pulse: `done` drops the same cycle and the run repeats.

Source files
------------

// File: rtl/hamming_enc_seq.sv
// Sequencer for the (16,11) Hamming encode job: reads 11-bit messages, hands them to an external
// encoder and writes the 16-bit codewords back. 5 cycles per message; no backpressure, done after 5*NUM_MSG cycles.
module hamming_enc_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic [AW-1:0] o_mem_addr,
    input  logic [7:0]    i_mem_rd_data,
    output logic          o_mem_wr_en,
    output logic [7:0]    o_mem_wr_data,
    output logic [10:0]   o_enc_data,
    input  logic [15:0]   i_enc_code,
    output logic          o_busy,
    output logic          o_done
);
    localparam int IW = $clog2(NUM_MSG + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    if (NUM_MSG < 1) begin : g_bad_num
        $error("hamming_enc_seq: NUM_MSG must be at least 1");
    end
    if ((SRC_BASE + 2 * NUM_MSG - 1) >= (2 ** AW) || (DST_BASE + 2 * NUM_MSG - 1) >= (2 ** AW)) begin : g_bad_range
        $error("hamming_enc_seq: source or destination region exceeds address space");
    end
    if (!((SRC_BASE + 2 * NUM_MSG <= DST_BASE) || (DST_BASE + 2 * NUM_MSG <= SRC_BASE))) begin : g_bad_overlap
        $error("hamming_enc_seq: source and destination regions overlap");
    end

    typedef enum logic [2:0] {
        S_RD_LO,
        S_RD_HI,
        S_ENC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_lo;
    logic [2:0]    r_hi;
    logic [15:0]   r_code;

    logic [AW-1:0] w_off;
    logic [AW-1:0] w_src_lo;
    logic [AW-1:0] w_src_hi;
    logic [AW-1:0] w_dst_lo;
    logic [AW-1:0] w_dst_hi;
    logic          w_unused_rd_bits;

    // Upper bits of each message's high byte carry no payload.
    assign w_unused_rd_bits = ^i_mem_rd_data[7:3];

    assign w_off    = AW'({r_idx, 1'b0});
    assign w_src_lo = AW'(SRC_BASE) + w_off;
    assign w_src_hi = w_src_lo + AW'(1);
    assign w_dst_lo = AW'(DST_BASE) + w_off;
    assign w_dst_hi = w_dst_lo + AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_RD_LO;
            r_idx   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_code  <= '0;
        end else begin
            case (r_state)
                S_RD_LO: begin
                    r_lo    <= i_mem_rd_data;
                    r_state <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_hi    <= i_mem_rd_data[2:0];
                    r_state <= S_ENC;
                end
                S_ENC: begin
                    r_code  <= i_enc_code;
                    r_state <= S_WR_LO;
                end
                S_WR_LO: r_state <= S_WR_HI;
                S_WR_HI: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_state <= S_RD_LO;
                    end
                end
                default: r_state <= S_DONE;
            endcase
        end
    end

    // Reset gates the strobes combinationally so nothing escapes during the reset cycle itself.
    always_comb begin
        o_mem_addr    = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = '0;
        case (r_state)
            S_RD_LO: o_mem_addr = w_src_lo;
            S_RD_HI: o_mem_addr = w_src_hi;
            S_ENC:   o_mem_addr = w_src_hi;
            S_WR_LO: begin
                o_mem_addr    = w_dst_lo;
                o_mem_wr_en   = !i_reset;
                o_mem_wr_data = i_reset ? 8'h00 : r_code[7:0];
            end
            S_WR_HI: begin
                o_mem_addr    = w_dst_hi;
                o_mem_wr_en   = !i_reset;
                o_mem_wr_data = i_reset ? 8'h00 : r_code[15:8];
            end
            default: o_mem_addr = '0;
        endcase
    end

    assign o_enc_data = {r_hi, r_lo};
    assign o_busy     = !i_reset && (r_state != S_DONE);
    assign o_done     = !i_reset && (r_state == S_DONE);

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Randomized scoreboard bench for hamming_enc_seq with a behavioural memory and Hamming encoder.
module tb_hamming_enc_seq;
    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [10:0]   enc_data;
    logic [15:0]   enc_code;
    logic          busy;
    logic          done;

    logic [7:0] mem [0:255];
    logic [7:0] exp_mem [0:63];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_dat = 8'h00;
    logic [7:0] msg_lo [N];
    logic [7:0] msg_hi [N];

    int cnt = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] dat;
    } wr_t;
    wr_t         wr_q[$];
    logic [10:0] enc_q[$];

    hamming_enc_seq #(.NUM_MSG(N), .SRC_BASE(SRC), .DST_BASE(DST), .AW(AW)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .o_mem_addr    (mem_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_wr_data (mem_wr_data),
        .o_enc_data    (enc_data),
        .i_enc_code    (enc_code),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    // Extended Hamming: positions 1..15, parity at powers of two, overall parity at bit 0.
    function automatic logic [15:0] ham(input logic [10:0] d);
        logic [15:0] c;
        logic        x;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p < 16; p++)
                if (((p & (1 << b)) != 0) && (p != (1 << b))) x = x ^ c[p];
            c[1 << b] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    assign mem_rd_data = mem[mem_addr];
    assign enc_code    = ham(enc_data);

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else if (ld_en) mem[ld_addr] <= ld_dat;
    end

    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle status checks plus scoreboard pops for writes and encoder presentations.
    always @(negedge clk) begin
        if (reset) begin
            chk("wr_en_in_reset", 32'(mem_wr_en), 32'd0);
            chk("busy_in_reset", 32'(busy), 32'd0);
            chk("done_in_reset", 32'(done), 32'd0);
        end else begin
            chk($sformatf("busy_c%0d", cnt), 32'(busy), 32'(cnt < 5 * N));
            chk($sformatf("done_c%0d", cnt), 32'(done), 32'(cnt >= 5 * N));
            if (mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0h cycle=%0d", mem_addr, mem_wr_data, cnt);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wr_data), 32'(e.dat));
                    chk("wr_cycle", 32'(cnt), 32'(e.cyc));
                end
            end
            if ((cnt < 5 * N) && (cnt % 5 == 2)) begin
                if (enc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL enc_underflow cycle=%0d enc_data=%0h", cnt, enc_data);
                end else begin
                    chk("enc_data", 32'(enc_data), 32'(enc_q.pop_front()));
                end
            end
        end
    end

    task automatic load(input int a, input logic [7:0] d);
        ld_addr    = 8'(a);
        ld_dat     = d;
        ld_en      = 1'b1;
        exp_mem[a] = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic load_msgs();
        for (int i = 0; i < N; i++) begin
            load(SRC + 2 * i, msg_lo[i]);
            load(SRC + 2 * i + 1, msg_hi[i]);
        end
    endtask

    task automatic arm();
        logic [10:0] d;
        logic [15:0] c;
        wr_q.delete();
        enc_q.delete();
        for (int i = 0; i < N; i++) begin
            d = {msg_hi[i][2:0], msg_lo[i]};
            c = ham(d);
            enc_q.push_back(d);
            wr_q.push_back('{cyc: 5 * i + 3, addr: 8'(DST + 2 * i), dat: c[7:0]});
            wr_q.push_back('{cyc: 5 * i + 4, addr: 8'(DST + 2 * i + 1), dat: c[15:8]});
            exp_mem[DST + 2 * i]     = c[7:0];
            exp_mem[DST + 2 * i + 1] = c[15:8];
        end
    endtask

    task automatic release_run();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic begin_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_q.delete();
        enc_q.delete();
    endtask

    task automatic finish_run(input string tag);
        repeat (5 * N + 2) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
        chk({tag, "_enc_left"}, 32'(enc_q.size()), 32'd0);
        for (int a = 0; a < 64; a++)
            chk($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(exp_mem[a]));
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int a = DST; a < 64; a++) load(a, 8'hA5);

        for (int i = 0; i < N; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_msgs(); arm(); release_run(); finish_run("rand");

        begin_reset();
        for (int i = 0; i < N; i++) begin msg_lo[i] = 8'h00; msg_hi[i] = 8'h00; end
        load_msgs(); arm(); release_run(); finish_run("zeros");

        begin_reset();
        for (int i = 0; i < N; i++) begin msg_lo[i] = 8'hFF; msg_hi[i] = 8'h07; end
        load_msgs(); arm(); release_run(); finish_run("ones");
        for (int a = DST; a < DST + 2 * N; a++)
            chk($sformatf("ones_ff%0d", a), 32'(mem[a]), 32'hFF);

        begin_reset();
        for (int i = 0; i < N; i++) begin msg_lo[i] = 8'h00; msg_hi[i] = 8'hF8; end
        load_msgs(); arm(); release_run(); finish_run("himask");

        begin_reset();
        for (int i = 0; i < N; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_msgs(); arm(); release_run();
        repeat (32) @(posedge clk);
        #1;
        reset = 1'b1;
        wr_q.delete();
        enc_q.delete();
        arm();
        @(posedge clk);
        #1;
        reset = 1'b0;
        finish_run("midrst");

        repeat (20) @(negedge clk);
        chk("idle_done", 32'(done), 32'd1);

        begin_reset();
        @(negedge clk);
        chk("done_drop", 32'(done), 32'd0);
        arm();
        release_run();
        finish_run("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
